// File: rtl/instr_fetch_pkg.sv
// Shared types and encodings for the instruction fetch front end.
// IF_MISALIGN_CHECK_EN (optional) enables the misaligned-redirect fault path.
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef NOP
`define NOP 32'h0000_0013
`endif
`ifndef PC_STEP
`define PC_STEP 32'd4
`endif
`ifndef FETCH_RUN
`define FETCH_RUN 1'b0
`endif
`ifndef FETCH_FAULT
`define FETCH_FAULT 1'b1
`endif

package instr_fetch_pkg;

  typedef enum logic {
    RUN   = `FETCH_RUN,
    FAULT = `FETCH_FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]              pc;
    logic [`INSTR_SIZE-1:0]   instr;
  } fetch_entry_t;

  // What decode sees when the buffer holds nothing.
  localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0, instr: `NOP};

endpackage

// File: rtl/fetch_fifo.sv
// Registered FIFO of {pc, instr} entries between the memory response and decode.
// Flush has priority over push/pop; head shows EMPTY_ENTRY when empty.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  fetch_entry_t              push_data,
  input  logic                      pop,
  output fetch_entry_t              head,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_pop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign do_pop = pop && !empty;
  assign head   = empty ? EMPTY_ENTRY : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= push_data;
  end

  // The issue throttle upstream keeps a free slot for every response in flight.
  always @(posedge clk) begin
    if (!rst && !flush && push && !do_pop) assert (!full);
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, in-order imem requests, response buffer, redirect flush.
// IF_MISALIGN_CHECK_EN: a misaligned redirect parks the unit in FAULT until reset.
//
//   state | meaning
//   RUN   | normal fetch
//   FAULT | misaligned redirect seen; no issue, nothing to decode
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [31:0]              imem_addr,
  input  logic                     imem_rsp_valid,
  input  logic [`INSTR_SIZE-1:0]   imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [`INSTR_SIZE-1:0]   if_instr,
  output logic [31:0]              if_pc,
  output logic                     fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t   state;
  logic [31:0]    pc_q;
  logic [31:0]    rsp_pc;
  logic [CW-1:0]  outstanding;
  logic [CW-1:0]  discard;
  logic [CW-1:0]  fifo_count;
  logic           fifo_empty;
  logic           fifo_full;
  fetch_entry_t   head;
  logic [31:0]    redir_pc;
  logic           redir_fault;
  logic [CW:0]    in_flight;
  logic           req_fire;
  logic           rsp_keep;
  logic           pop;

`ifdef IF_MISALIGN_CHECK_EN
  assign redir_pc    = redirect_pc;
  assign redir_fault = (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = !rst && (state == FAULT);
`else
  assign redir_pc    = redirect_pc & ~32'h3;
  assign redir_fault = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  // Requests in flight plus buffered words never exceed the buffer size.
  assign in_flight      = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && (state == RUN) && !redirect_valid && !fifo_full
                          && (in_flight < (CW+1)'(FIFO_DEPTH));
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = !rst && imem_rsp_valid && (discard == '0);

  assign if_valid = !rst && (state == RUN) && !fifo_empty && !redirect_valid;
  assign pop      = if_valid && if_ready;
  assign if_instr = rst ? `NOP : head.instr;
  assign if_pc    = rst ? 32'h0 : head.pc;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data ('{pc: rsp_pc, instr: imem_rsp_data}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc_q        <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        pc_q    <= redir_pc;
        rsp_pc  <= redir_pc;
        // Everything still in flight once this cycle's response retires is stale.
        discard <= outstanding - CW'(imem_rsp_valid);
        if (redir_fault) state <= FAULT;
      end else begin
        if (req_fire) pc_q <= pc_q + `PC_STEP;
        if (imem_rsp_valid) begin
          if (discard != '0) discard <= discard - CW'(1);
          else               rsp_pc  <= rsp_pc + `PC_STEP;
        end
      end
    end
  end

endmodule
